// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline stage registers.
// Holds the stage occupancy state encoding, the ID/EX payload layout
// and the NOP payload used as the bubble/reset value.
package pipe_pkg;

  // Occupancy of a skid-buffered stage: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int ID_EX_WIDTH = 208;

  // Decode-to-execute payload, packed MSB first.
  typedef struct packed {
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic [4:0]  write_addr;
    logic [4:0]  reg1_addr;
    logic [4:0]  reg2_addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] jump_op1;
    logic [31:0] jump_op2;
    logic        wen;
  } id_ex_payload_t;

  // All-zero payload: no register write, so it behaves as a NOP bubble.
  localparam id_ex_payload_t ID_EX_NOP = '0;

  // Number of entries held in a given state.
  function automatic logic [1:0] occupancy_of(input stage_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_data_reg.sv
// Payload register with load enable and a synchronous load of a fixed
// init value, used both for reset and for flushing to a bubble.
module pipe_data_reg #(
  parameter int                    DATA_WIDTH = 208,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Reset beats clear, clear beats a normal load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= INIT_VALUE;
    end else if (clear) begin
      q <= INIT_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry
// skid buffer. in_ready depends only on registered state, which cuts the
// combinational ready path between neighbouring stages. A flush (taken
// jump) empties the stage; an output transfer in the same cycle still
// completes, an input transfer in the same cycle is discarded.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = ID_EX_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE  = {DATA_WIDTH{1'b0}},
  parameter bit                    FLUSH_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  stage_state_e          state;
  stage_state_e          state_next;
  logic                  main_valid;
  logic                  skid_valid;
  logic                  in_fire;
  logic                  out_fire;
  logic                  main_load;
  logic                  main_sel_skid;
  logic                  skid_load;
  logic                  data_clear;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);
  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign out_data   = main_data;
  assign occupancy  = occupancy_of(state);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = main_valid & out_ready;
  assign data_clear = flush_in & FLUSH_ZERO;
  assign main_d     = main_sel_skid ? skid_data : in_data;

  // State register; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state and register load enables from the handshake fires.
  always_comb begin
    state_next    = state;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush_in) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            main_load  = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_next = TWO;
            skid_load  = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_next    = ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  pipe_data_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VALUE (RST_VALUE)
  ) u_main_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (data_clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_data)
  );

  pipe_data_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VALUE (RST_VALUE)
  ) u_skid_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (data_clear),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_data)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. Two instances share the same
// stimulus, one flushing to a zero bubble and one keeping its data, and
// both are compared every cycle against a queue-based model.
module tb_pipe_stage_skid;

  localparam int DW = 208;
  typedef logic [DW-1:0] word_t;

  logic       clk;
  logic       rst;
  logic       flush_in;
  logic       in_valid;
  word_t      in_data;
  logic       out_ready;
  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  word_t      out_data0, out_data1;
  logic [1:0] occupancy0, occupancy1;

  int    checks;
  int    failures;
  int    delivered;
  word_t model_q[$];
  word_t last_head_fz1;
  word_t last_head_fz0;

  pipe_stage_skid #(
    .DATA_WIDTH (DW),
    .RST_VALUE  ({DW{1'b0}}),
    .FLUSH_ZERO (1'b1)
  ) dut_fz1 (
    .clk       (clk),
    .rst       (rst),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .occupancy (occupancy0)
  );

  pipe_stage_skid #(
    .DATA_WIDTH (DW),
    .RST_VALUE  ({DW{1'b0}}),
    .FLUSH_ZERO (1'b0)
  ) dut_fz0 (
    .clk       (clk),
    .rst       (rst),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .occupancy (occupancy1)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance the reference queue by one clock edge using the current inputs.
  task automatic updateModel(input logic r, input logic f, input logic v,
                             input logic rdy, input word_t d);
    bit accept;
    bit deliver;
    accept  = v && (model_q.size() < 2);
    deliver = (model_q.size() > 0) && rdy;
    if (!r) begin
      model_q.delete();
      last_head_fz1 = '0;
      last_head_fz0 = '0;
    end else begin
      if (deliver) begin
        void'(model_q.pop_front());
        delivered++;
      end
      if (f) begin
        model_q.delete();
        last_head_fz1 = '0;
      end else if (accept) begin
        model_q.push_back(d);
      end
      if (model_q.size() > 0) begin
        last_head_fz1 = model_q[0];
        last_head_fz0 = model_q[0];
      end
    end
  endtask

  // Compare both instances against the model.
  task automatic compareAll();
    word_t exp_valid;
    word_t exp_ready;
    word_t exp_occ;
    exp_valid = word_t'(model_q.size() > 0);
    exp_ready = word_t'(model_q.size() < 2);
    exp_occ   = word_t'(model_q.size());
    checkOutput("out_valid_fz1", word_t'(out_valid0), exp_valid);
    checkOutput("in_ready_fz1",  word_t'(in_ready0),  exp_ready);
    checkOutput("occupancy_fz1", word_t'(occupancy0), exp_occ);
    checkOutput("out_data_fz1",  out_data0,           last_head_fz1);
    checkOutput("out_valid_fz0", word_t'(out_valid1), exp_valid);
    checkOutput("in_ready_fz0",  word_t'(in_ready1),  exp_ready);
    checkOutput("occupancy_fz0", word_t'(occupancy1), exp_occ);
    checkOutput("out_data_fz0",  out_data1,           last_head_fz0);
  endtask

  // Drive one cycle of inputs, step the model, then check after the edge.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic rdy, input word_t d);
    rst       = r;
    flush_in  = f;
    in_valid  = v;
    out_ready = rdy;
    in_data   = d;
    updateModel(r, f, v, rdy, d);
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  function automatic word_t randomWord();
    word_t w;
    w = '0;
    for (int k = 0; k < 7; k++) begin
      w = {w[DW-33:0], 32'($urandom)};
    end
    return w;
  endfunction

  // Directed scenarios followed by a long random run.
  initial begin
    int base_delivered;
    checks        = 0;
    failures      = 0;
    delivered     = 0;
    last_head_fz1 = '0;
    last_head_fz0 = '0;

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, word_t'(8'hAB));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, word_t'(8'hAB));
    checkOutput("reset_out_data", out_data0, '0);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, word_t'(i));
      checkOutput("stream_head", out_data0, word_t'(i));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, word_t'(8'h10));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, word_t'(8'h11));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, word_t'(8'h12));
    checkOutput("bp_stalled_head", out_data0, word_t'(8'h10));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, word_t'(8'h12));
    checkOutput("bp_second", out_data0, word_t'(8'h11));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, word_t'(8'h12));
    checkOutput("bp_third", out_data0, word_t'(8'h12));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, word_t'(8'h21));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, word_t'(8'h22));
    checkOutput("flush_one_data", out_data0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, word_t'(8'h30));
    base_delivered = delivered;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, '0);
    checkOutput("flush_out_fire_count", word_t'(delivered - base_delivered), word_t'(1));
    checkOutput("flush_keep_data", out_data1, word_t'(8'h30));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, word_t'(8'h40 + i));
    end

    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(199) != 0),
                    ($urandom_range(15) == 0),
                    ($urandom_range(9) < 7),
                    ($urandom_range(9) < 6),
                    randomWord());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer and a branch/jump flush. It replaces the per-field hold-flop banks between decode and execute, and can be reused at any stage boundary of the core. It carries an opaque packed payload, sustains one transfer per cycle, and breaks the combinational ready path between stages.

## Interface
- DATA_WIDTH, 208, payload width (instr_addr, instr, write/reg1/reg2 addr, op1, op2, jump_op1, jump_op2, wen packed).
- RST_VALUE, {DATA_WIDTH{1'b0}}, value loaded into both data registers on reset.
- FLUSH_ZERO, 1, when 1 a flush also loads RST_VALUE into both data registers (NOP bubble); when 0 the data registers keep their contents.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush_in  in  1  jump taken; kill all buffered entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  downstream payload, driven from the main register.
- occupancy  out  2  entries held: 0, 1 or 2.

## Operation
- Storage: main register (main_data, main_valid) and skid register (skid_data, skid_valid).
- Fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (neither valid), ONE (main only), TWO (main and skid). skid_valid without main_valid never occurs.
- Outputs: out_valid = main_valid; out_data = main_data; in_ready = ~skid_valid; occupancy = main_valid + skid_valid.
- Transitions when flush_in = 0:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data. in_fire & ~out_fire -> TWO, skid <= in_data. ~in_fire & out_fire -> EMPTY. Otherwise hold.
  - TWO: in_ready = 0. out_fire -> ONE, main <= skid_data. Otherwise hold.
- Flush (flush_in = 1): next state EMPTY regardless of state or fires.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle is a completed transfer; downstream keeps it.
  - FLUSH_ZERO = 1 loads RST_VALUE into main_data and skid_data; FLUSH_ZERO = 0 leaves data unchanged.
- Reset (rst = 0 at an edge): EMPTY, main_data = skid_data = RST_VALUE. Reset overrides flush and any fire.

## Timing
- Reset values: out_valid 0, out_data RST_VALUE, occupancy 0, in_ready 1.
- Latency in_fire -> out_valid: 1 cycle. Throughput: 1 transfer/cycle when out_ready is held high.
- in_ready is a registered function of state; there is no combinational path from out_ready or flush_in to in_ready.
- out_valid and out_data are registered and do not change while out_valid = 1 & out_ready = 0 (AXI-style hold), except on flush or reset.
- Flush asserted in cycle N: out_valid = 0 and in_ready = 1 from cycle N+1. Flush held for several cycles keeps the stage EMPTY.
- Ordering is FIFO. The skid entry always leaves after the main entry.

## Structure
- Package pipe_pkg holds:
  - the state enum (EMPTY/ONE/TWO, 2 bits);
  - the ID/EX payload struct and its width constant (208);
  - the NOP payload constant used as RST_VALUE.
- Sub-module pipe_data_reg: a DATA_WIDTH register with load enable and sync load of a reset/flush value. Instantiate it twice (main, skid).
- Top-level: the FSM and the mux selecting main's source (in_data vs skid_data).

## Test plan
- Reset: hold rst = 0 for 2 cycles with in_valid = 1, in_data = 0xAB -> out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1.
- Streaming: out_ready = 1, send 0x1..0x8 back-to-back -> 0x1..0x8 appear on consecutive cycles, 1-cycle latency, in_ready never drops.
- Backpressure: out_ready = 0, send 0x10, 0x11 -> occupancy = 2, in_ready = 0, 0x12 is held upstream. Raise out_ready -> 0x10, 0x11, 0x12 delivered in order with no loss or duplicate.
- Flush in TWO with a simultaneous in_fire is impossible (in_ready = 0). Flush in ONE with in_fire of 0x22 -> next cycle occupancy = 0, 0x22 never appears, and out_data = 0 with FLUSH_ZERO = 1.
- Flush with simultaneous out_fire of 0x30 -> 0x30 counted delivered exactly once, stage EMPTY next cycle. Repeat with FLUSH_ZERO = 0 -> out_data retains 0x30 while out_valid = 0.
- Random valid/ready/flush for 10k cycles against a scoreboard model -> no reorder, no duplicate, no dropped non-flushed entry, out_data stable while stalled.
